mac_share_arbiter: RTL and testbench

- Shares one registered multiply-accumulate unit (DATA_OUT = A*B + C, 8-bit, one-cycle registered latency) between N_REQ requesters.
- Arbitrates requests round-robin, captures the winner's operands and drives them to the MAC.
- Waits out the MAC latency, then returns the result to the winner over a valid/ready response handshake.
- Sits between client blocks and the MAC instance; exactly one operation is in flight at a time.

---
 rtl/mac_share_arbiter.sv | 150 +++++++++++++++
 tb/tb_mac_share_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_share_arbiter.sv
// Round-robin arbiter that shares one registered multiply-accumulate unit between N_REQ clients.
// Optional per-requester grant counters are enabled by defining MAC_SHARE_ARBITER_STATS_EN.
module mac_share_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned MAC_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*DW-1:0]      req_a,
    input  logic [N_REQ*DW-1:0]      req_b,
    input  logic [N_REQ*DW-1:0]      req_c,
    output logic [N_REQ-1:0]         resp_valid,
    input  logic [N_REQ-1:0]         resp_ready,
    output logic [DW-1:0]            resp_data,
    output logic [$clog2(N_REQ)-1:0] resp_id,
    output logic [DW-1:0]            mac_a,
    output logic [DW-1:0]            mac_b,
    output logic [DW-1:0]            mac_c,
    input  logic [DW-1:0]            mac_result
`ifdef MAC_SHARE_ARBITER_STATS_EN
    ,
    input  logic [$clog2(N_REQ)-1:0] stat_sel,
    output logic [15:0]              stat_cnt
`endif
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     rr_ptr_q;
    logic [IW-1:0]     resp_id_q;
    logic [CW-1:0]     cnt_q;
    logic [DW-1:0]     mac_a_q, mac_b_q, mac_c_q;
    logic [DW-1:0]     resp_data_q;
    logic [N_REQ-1:0]  resp_valid_q;

    logic              grant_found;
    logic [IW-1:0]     grant_idx;
    logic [IW-1:0]     grant_next;
    logic              req_hs;
    logic              resp_hs;

    // Search starts at rr_ptr so the last winner drops to lowest priority.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % N_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(idx);
            end
        end
    end

    assign grant_next = (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IW'(1);
    assign req_hs     = (state_q == StIdle) && grant_found && !reset;
    assign resp_hs    = (state_q == StResp) && resp_ready[resp_id_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_found) state_d = StBusy;
            StBusy:  if (cnt_q == '0) state_d = StResp;
            StResp:  if (resp_hs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // req_ready is held low while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (req_hs) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            resp_id_q    <= '0;
            cnt_q        <= '0;
            mac_a_q      <= '0;
            mac_b_q      <= '0;
            mac_c_q      <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= '0;
        end else begin
            if (req_hs) begin
                mac_a_q   <= req_a[grant_idx*DW +: DW];
                mac_b_q   <= req_b[grant_idx*DW +: DW];
                mac_c_q   <= req_c[grant_idx*DW +: DW];
                resp_id_q <= grant_idx;
                rr_ptr_q  <= grant_next;
                cnt_q     <= CW'(MAC_LAT);
            end
            if (state_q == StBusy) begin
                if (cnt_q == '0) begin
                    resp_data_q             <= mac_result;
                    resp_valid_q[resp_id_q] <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
            if (resp_hs) begin
                resp_valid_q <= '0;
            end
        end
    end

    assign mac_a      = mac_a_q;
    assign mac_b      = mac_b_q;
    assign mac_c      = mac_c_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign resp_valid = resp_valid_q;

`ifdef MAC_SHARE_ARBITER_STATS_EN
    logic [15:0] stat_q [N_REQ];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else if (req_hs && (stat_q[grant_idx] != 16'hFFFF)) begin
            stat_q[grant_idx] <= stat_q[grant_idx] + 16'd1;
        end
    end

    assign stat_cnt = stat_q[stat_sel];
`endif

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Directed bench for mac_share_arbiter with a behavioural one-cycle registered MAC.
// Stats checks are compiled when MAC_SHARE_ARBITER_STATS_EN is defined.
module tb_mac_share_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a, req_b, req_c;
    logic [3:0]  resp_valid;
    logic [3:0]  resp_ready;
    logic [7:0]  resp_data;
    logic [1:0]  resp_id;
    logic [7:0]  mac_a, mac_b, mac_c;
    logic [7:0]  mac_result;
`ifdef MAC_SHARE_ARBITER_STATS_EN
    logic [1:0]  stat_sel;
    logic [15:0] stat_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mac_share_arbiter #(
        .N_REQ   (4),
        .DW      (8),
        .MAC_LAT (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_c      (mac_c),
        .mac_result (mac_result)
`ifdef MAC_SHARE_ARBITER_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_cnt   (stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mac_result <= 8'(mac_a * mac_b + mac_c);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_c[i*8 +: 8] = c;
    endtask

`ifdef MAC_SHARE_ARBITER_STATS_EN
    task automatic run_op(input int i);
        req_valid = 4'(1 << i);
        tick();
        req_valid = '0;
        tick();
        tick();
        resp_ready = 4'(1 << i);
        tick();
        resp_ready = '0;
    endtask
`endif

    initial begin
        int g;
        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_c      = '0;
        resp_ready = '0;
`ifdef MAC_SHARE_ARBITER_STATS_EN
        stat_sel   = '0;
`endif
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_data", 32'(resp_data), 0);
        check("rst_resp_id", 32'(resp_id), 0);
        check("rst_mac_a", 32'(mac_a), 0);
        check("rst_mac_b", 32'(mac_b), 0);
        check("rst_mac_c", 32'(mac_c), 0);
        reset = 1'b0;

        // Single request from requester 0: 3*4+5 = 17
        tick();
        set_req(0, 8'd3, 8'd4, 8'd5);
        req_valid = 4'b0001;
        #1;
        check("single_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        check("single_mac_a", 32'(mac_a), 3);
        check("single_mac_b", 32'(mac_b), 4);
        check("single_mac_c", 32'(mac_c), 5);
        check("single_busy_rdy", 32'(req_ready), 0);
        check("single_t1_rv", 32'(resp_valid), 0);
        tick();
        check("single_t2_rv", 32'(resp_valid), 0);
        tick();
        check("single_t3_rv", 32'(resp_valid), 32'h1);
        check("single_data", 32'(resp_data), 17);
        check("single_id", 32'(resp_id), 0);
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;
        check("single_t4_rv", 32'(resp_valid), 0);

        // Requester 1: 16*16+7 = 263, truncated to 7
        set_req(1, 8'd16, 8'd16, 8'd7);
        req_valid = 4'b0010;
        #1;
        check("wrap_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        tick();
        check("wrap_rv", 32'(resp_valid), 32'h2);
        check("wrap_data", 32'(resp_data), 7);
        check("wrap_id", 32'(resp_id), 1);
        resp_ready = 4'b0010;
        tick();
        resp_ready = '0;
        check("wrap_done_rv", 32'(resp_valid), 0);

        // Round robin from rr_ptr=0 with everyone requesting; result i is 2*(i+1)+i
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 8'(i + 1), 8'd2, 8'(i));
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            #1;
            check("rr_grant", 32'(req_ready), 32'(1 << g));
            tick();
            check("rr_busy_rdy", 32'(req_ready), 0);
            check("rr_mac_a", 32'(mac_a), 32'(g + 1));
            check("rr_mac_c", 32'(mac_c), 32'(g));
            tick();
            tick();
            check("rr_rv", 32'(resp_valid), 32'(1 << g));
            check("rr_data", 32'(resp_data), 32'(3 * g + 2));
            check("rr_id", 32'(resp_id), 32'(g));
            resp_ready = 4'b1111;
            tick();
            resp_ready = '0;
        end

        // Backpressure on requester 2 while others wait; rr_ptr is 1 here
        req_valid = 4'b0100;
        #1;
        check("bp_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b1111;
        #1;
        check("bp_busy_rdy", 32'(req_ready), 0);
        tick();
        tick();
        check("bp_rv0", 32'(resp_valid), 32'h4);
        check("bp_data0", 32'(resp_data), 8);
        resp_ready = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_rv", 32'(resp_valid), 32'h4);
            check("bp_hold_data", 32'(resp_data), 8);
            check("bp_hold_id", 32'(resp_id), 2);
            check("bp_hold_rdy", 32'(req_ready), 0);
        end
        resp_ready = 4'b0100;
        tick();
        resp_ready = '0;
        #1;
        check("bp_release_rv", 32'(resp_valid), 0);
        check("bp_next_grant", 32'(req_ready), 32'h8);

        // Reset during BUSY aborts the op for requester 3
        tick();
        check("rm_mac_a", 32'(mac_a), 4);
        reset = 1'b1;
        tick();
        check("rm_mac_a0", 32'(mac_a), 0);
        check("rm_mac_b0", 32'(mac_b), 0);
        check("rm_mac_c0", 32'(mac_c), 0);
        check("rm_data0", 32'(resp_data), 0);
        check("rm_id0", 32'(resp_id), 0);
        check("rm_rv0", 32'(resp_valid), 0);
        check("rm_rdy0", 32'(req_ready), 0);
        reset = 1'b0;
        #1;
        check("rm_first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("rm_no_stale_rv", 32'(resp_valid), 0);
        tick();
        tick();
        check("rm_rv", 32'(resp_valid), 32'h1);
        check("rm_data", 32'(resp_data), 2);
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;

`ifdef MAC_SHARE_ARBITER_STATS_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_op(1);
        run_op(1);
        run_op(1);
        run_op(3);
        stat_sel = 2'd1;
        #1;
        check("stat_req1", 32'(stat_cnt), 3);
        stat_sel = 2'd3;
        #1;
        check("stat_req3", 32'(stat_cnt), 1);
        stat_sel = 2'd0;
        #1;
        check("stat_req0", 32'(stat_cnt), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stat_sel = 2'd1;
        #1;
        check("stat_rst1", 32'(stat_cnt), 0);
        stat_sel = 2'd3;
        #1;
        check("stat_rst3", 32'(stat_cnt), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
